encoder_fec: RTL and testbench

- Loopback FEC block for 8-bit messages: encode, pass through an internal "channel" register, then decode and correct.
- Each message nibble is encoded with extended Hamming (8,4) SEC-DED. This corrects any single-bit error per nibble codeword.
- The internal codeword register `modulated_message` is the error-injection point for verification.
- Two-stage pipeline. Output order equals input order.

---
 rtl/encoder_fec.sv | 92 +++++++++
 tb/tb_encoder_fec.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/encoder_fec.sv
// Loopback FEC: two extended Hamming (8,4) SEC-DED codewords per byte, a channel
// register that can be corrupted, then syndrome decode with single-bit correction.
package encoder_fec_pkg;
  typedef logic [7:0] message_data_t;
endpackage

module encoder_fec
  import encoder_fec_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          req,
  input  message_data_t data_in,
  output logic          ack,
  output message_data_t data_out
);

  // Channel register: [3]/[2] hold the high-nibble codeword, [1]/[0] the low one.
  logic [3:0][3:0] modulated_message;
  logic [3:0][3:0] modulated_message_d;

  logic          valid1_q, valid1_d;
  logic          ack_q, ack_d;
  message_data_t data_out_q, data_out_d;
  message_data_t decoded;

  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] c;
    c    = '0;
    c[3] = d[0];
    c[5] = d[1];
    c[6] = d[2];
    c[7] = d[3];
    c[1] = d[0] ^ d[1] ^ d[3];
    c[2] = d[0] ^ d[2] ^ d[3];
    c[4] = d[1] ^ d[2] ^ d[3];
    c[0] = ^c[7:1];
    return c;
  endfunction

  // Overall parity separates single errors (correctable) from doubles (left alone).
  function automatic logic [3:0] decode(input logic [7:0] c);
    logic [7:0] cc;
    logic [2:0] s;
    logic       p;
    cc   = c;
    s[0] = c[1] ^ c[3] ^ c[5] ^ c[7];
    s[1] = c[2] ^ c[3] ^ c[6] ^ c[7];
    s[2] = c[4] ^ c[5] ^ c[6] ^ c[7];
    p    = ^c;
    if (p && (s != 3'd0)) begin
      cc[s] = ~cc[s];
    end
    return {cc[7], cc[6], cc[5], cc[3]};
  endfunction

  assign decoded = {decode({modulated_message[3], modulated_message[2]}),
                    decode({modulated_message[1], modulated_message[0]})};

  always_comb begin
    modulated_message_d = modulated_message;
    valid1_d            = 1'b0;
    ack_d               = valid1_q;
    data_out_d          = data_out_q;
    if (en && req) begin
      modulated_message_d = {encode(data_in[7:4]), encode(data_in[3:0])};
      valid1_d            = 1'b1;
    end
    if (valid1_q) begin
      data_out_d = decoded;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modulated_message <= '0;
      valid1_q          <= 1'b0;
      ack_q             <= 1'b0;
      data_out_q        <= '0;
    end else begin
      modulated_message <= modulated_message_d;
      valid1_q          <= valid1_d;
      ack_q             <= ack_d;
      data_out_q        <= data_out_d;
    end
  end

  assign ack      = ack_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_encoder_fec.sv
// Randomised self-checking bench for encoder_fec with a position-based Hamming
// model and channel corruption injected by forcing the codeword register.
module tb_encoder_fec;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       req;
  logic [7:0] data_in;
  logic       ack;
  logic [7:0] data_out;

  int totalCount = 0;
  int badCount   = 0;
  logic [15:0] forceVal;

  encoder_fec dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .data_in  (data_in),
    .ack      (ack),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Parity bit at position 2^k covers every codeword position with bit k set.
  function automatic logic [7:0] modelEncode(input logic [3:0] d);
    logic [7:0] c;
    int dataPos[4] = '{3, 5, 6, 7};
    c = '0;
    for (int k = 0; k < 4; k++) c[dataPos[k]] = d[k];
    for (int p = 1; p <= 4; p = p * 2) begin
      for (int pos = 1; pos < 8; pos++) begin
        if ((pos & p) != 0 && pos != p) c[p] = c[p] ^ c[pos];
      end
    end
    c[0] = ^c[7:1];
    return c;
  endfunction

  function automatic logic [15:0] modelChannel(input logic [7:0] m);
    return {modelEncode(m[7:4]), modelEncode(m[3:0])};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; req = 1'b0; data_in = 8'h00;
    tick(); tick();
    totalCount += 3;
    if (ack !== 1'b0) begin badCount++; $display("[TB] FAIL reset_ack: got %b want 0", ack); end
    if (data_out !== 8'h00) begin badCount++; $display("[TB] FAIL reset_data: got %h want 00", data_out); end
    if (dut.modulated_message !== 16'h0000) begin
      badCount++; $display("[TB] FAIL reset_channel: got %h want 0000", dut.modulated_message);
    end
    rst_n = 1'b1;
    tick();
    en = 1'b1; req = 1'b1; data_in = 8'h11;
    tick();
    req = 1'b0;
    tick();
    totalCount++;
    if (ack !== 1'b1) begin badCount++; $display("[TB] FAIL premid_ack: got %b want 1", ack); end
    rst_n = 1'b0;
    #1;
    totalCount += 2;
    if (ack !== 1'b0) begin badCount++; $display("[TB] FAIL midreset_ack: got %b want 0", ack); end
    if (data_out !== 8'h00) begin badCount++; $display("[TB] FAIL midreset_data: got %h want 00", data_out); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_encode();
    en = 1'b1; req = 1'b1; data_in = 8'hA5;
    tick();
    req = 1'b0;
    totalCount += 2;
    if (dut.modulated_message !== modelChannel(8'hA5)) begin
      badCount++;
      $display("[TB] FAIL encode_channel: got %h want %h", dut.modulated_message, modelChannel(8'hA5));
    end
    if (ack !== 1'b0) begin badCount++; $display("[TB] FAIL encode_early_ack: got %b want 0", ack); end
    tick();
    totalCount += 2;
    if (ack !== 1'b1) begin badCount++; $display("[TB] FAIL encode_ack: got %b want 1", ack); end
    if (data_out !== 8'hA5) begin badCount++; $display("[TB] FAIL encode_data: got %h want a5", data_out); end
    tick();
    totalCount++;
    if (ack !== 1'b0) begin badCount++; $display("[TB] FAIL encode_ack_pulse: got %b want 0", ack); end
  endtask

  task automatic test_back_to_back(input int cycles);
    logic [7:0] expQ[$];
    logic       prevReq;
    logic [7:0] want;
    prevReq = 1'b0;
    en = 1'b1;
    for (int i = 0; i < cycles + 2; i++) begin
      if (i < cycles) begin
        req = 1'b1;
        data_in = 8'($urandom_range(0, 254));
        expQ.push_back(data_in);
      end else begin
        req = 1'b0;
      end
      tick();
      totalCount++;
      if (ack !== prevReq) begin
        badCount++; $display("[TB] FAIL stream_ack cycle %0d: got %b want %b", i, ack, prevReq);
      end
      if (ack === 1'b1 && expQ.size() > 0) begin
        want = expQ.pop_front();
        totalCount++;
        if (data_out !== want) begin
          badCount++; $display("[TB] FAIL stream_data cycle %0d: got %h want %h", i, data_out, want);
        end
      end
      prevReq = req;
    end
    totalCount++;
    if (expQ.size() != 0) begin
      badCount++; $display("[TB] FAIL stream_leftover: got %0d pending want 0", expQ.size());
    end
  endtask

  // Accept one message, corrupt the channel before stage 2 samples it, check the result.
  task automatic sendCorrupted(input logic [7:0] msg, input logic [15:0] flipMask, input string name);
    en = 1'b1; req = 1'b1; data_in = msg;
    tick();
    req = 1'b0;
    forceVal = modelChannel(msg) ^ flipMask;
    force dut.modulated_message = forceVal;
    tick();
    release dut.modulated_message;
    totalCount += 2;
    if (ack !== 1'b1) begin badCount++; $display("[TB] FAIL %s_ack: got %b want 1", name, ack); end
    if (data_out !== msg) begin
      badCount++; $display("[TB] FAIL %s_data mask %h: got %h want %h", name, flipMask, data_out, msg);
    end
  endtask

  task automatic test_single_bit();
    for (int b = 0; b < 16; b++) begin
      sendCorrupted(8'h3C, 16'(1) << b, "flip");
    end
  endtask

  task automatic test_random_flips(input int count);
    logic [15:0] mask;
    for (int i = 0; i < count; i++) begin
      mask = ($urandom_range(0, 99) < 5) ? (16'(1) << $urandom_range(0, 15)) : 16'h0000;
      sendCorrupted(8'($urandom_range(0, 255)), mask, "randflip");
    end
  endtask

  task automatic test_parity_bit();
    sendCorrupted(8'hFF, 16'h0100, "parity");
  endtask

  task automatic test_enable();
    en = 1'b0; req = 1'b1; data_in = 8'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      totalCount++;
      if (ack !== 1'b0) begin badCount++; $display("[TB] FAIL gated_ack %0d: got %b want 0", i, ack); end
    end
    en = 1'b1; data_in = 8'h5A;
    tick();
    en = 1'b0; data_in = 8'h33;
    tick();
    totalCount += 2;
    if (ack !== 1'b1) begin badCount++; $display("[TB] FAIL drain_ack: got %b want 1", ack); end
    if (data_out !== 8'h5A) begin badCount++; $display("[TB] FAIL drain_data: got %h want 5a", data_out); end
    tick();
    totalCount += 2;
    if (ack !== 1'b0) begin badCount++; $display("[TB] FAIL drain_ack_end: got %b want 0", ack); end
    if (data_out !== 8'h5A) begin badCount++; $display("[TB] FAIL drain_hold: got %h want 5a", data_out); end
    req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_encode();
    test_back_to_back(50000);
    test_single_bit();
    test_parity_bit();
    test_random_flips(600);
    test_enable();
    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
